// File: rtl/pipe_game_sequencer.sv
// pipe_game_sequencer: IDLE/PLAY/DEAD controller for the two-pipe Flappy Bird datapath.
// Inputs: clk, reset (sync, active-high), flap (1-cycle pulse), collide (level),
//         pipe0_x/pipe1_x (current pipe x positions).
// Outputs (all registered): pipes_reset, start0, start1, pipe_length0/1 (LFSR lengths),
//         score (saturating), playing, game_over.
// Optional: define HIGH_SCORE_EN to add the high_score output, captured on DEAD entry.
module pipe_game_sequencer #(
  parameter int N = 11,
  parameter int START_X = 640,
  parameter int SPACING = 320,
  parameter int BIRD_X = 100,
  parameter int DEAD_HOLD = 6250000,
  parameter int MAX_SCORE = 999,
  parameter logic [9:0] LFSR_SEED = 10'h2A5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flap,
  input  logic         collide,
  input  logic [N-1:0] pipe0_x,
  input  logic [N-1:0] pipe1_x,
  output logic         pipes_reset,
  output logic         start0,
  output logic         start1,
  output logic [9:0]   pipe_length0,
  output logic [9:0]   pipe_length1,
  output logic [9:0]   score,
`ifdef HIGH_SCORE_EN
  output logic [9:0]   high_score,
`endif
  output logic         playing,
  output logic         game_over
);
  localparam int CW = $clog2(DEAD_HOLD + 1) < 1 ? 1 : $clog2(DEAD_HOLD + 1);
  typedef enum logic [1:0] {IDLE, PLAY, DEAD} state_t;
  state_t state;
  logic [9:0] lfsr;
  logic p1_armed;
  logic [CW-1:0] hold;
  logic [N-1:0] prev_x0, prev_x1;
  logic cross0, cross1, arm;
  logic [10:0] sum;
  always_comb begin
    cross0 = pipe0_x == N'(BIRD_X) && prev_x0 != N'(BIRD_X);
    cross1 = pipe1_x == N'(BIRD_X) && prev_x1 != N'(BIRD_X);
    sum = {1'b0, score} + 11'(cross0) + 11'(cross1);
    arm = p1_armed || pipe0_x <= N'(START_X - SPACING);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pipes_reset <= 1'b1;
      start0 <= 1'b0;
      start1 <= 1'b0;
      score <= '0;
      playing <= 1'b0;
      game_over <= 1'b0;
      lfsr <= LFSR_SEED;
      pipe_length0 <= LFSR_SEED;
      pipe_length1 <= LFSR_SEED;
      p1_armed <= 1'b0;
      hold <= '0;
      prev_x0 <= N'(START_X);
      prev_x1 <= N'(START_X);
`ifdef HIGH_SCORE_EN
      high_score <= '0;
`endif
    end else begin
      lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
      prev_x0 <= pipe0_x;
      prev_x1 <= pipe1_x;
      if (pipe0_x == N'(START_X)) pipe_length0 <= lfsr;
      if (pipe1_x == N'(START_X)) pipe_length1 <= lfsr;
      case (state)
        IDLE: if (flap) begin
          state <= PLAY;
          score <= '0;
          pipes_reset <= 1'b0;
          start0 <= 1'b1;
          playing <= 1'b1;
        end
        PLAY: if (collide) begin
          // collision wins over any crossing in the same cycle
          state <= DEAD;
          start0 <= 1'b0;
          start1 <= 1'b0;
          playing <= 1'b0;
          game_over <= 1'b1;
          hold <= '0;
`ifdef HIGH_SCORE_EN
          if (score > high_score) high_score <= score;
`endif
        end else begin
          p1_armed <= arm;
          start1 <= arm;
          score <= sum > 11'(MAX_SCORE) ? 10'(MAX_SCORE) : sum[9:0];
        end
        DEAD: if (flap && hold >= CW'(DEAD_HOLD)) begin
          state <= IDLE;
          p1_armed <= 1'b0;
          hold <= '0;
          game_over <= 1'b0;
          pipes_reset <= 1'b1;
        end else if (hold < CW'(DEAD_HOLD)) hold <= hold + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_game_sequencer.sv
// tb_pipe_game_sequencer: random stimulus against a spec-level reference model.
module tb_pipe_game_sequencer;
  localparam int DH = 10;
  logic clk = 1'b0;
  logic reset, flap, collide;
  logic [10:0] pipe0_x, pipe1_x;
  logic pipes_reset, start0, start1, playing, game_over;
  logic [9:0] pipe_length0, pipe_length1, score;
`ifdef HIGH_SCORE_EN
  logic [9:0] high_score;
`endif
  int checks = 0, errors = 0;
  int m_state, m_score, m_hs, m_cnt, m_armed, m_lfsr, m_len0, m_len1, m_prev0, m_prev1;

  pipe_game_sequencer #(.DEAD_HOLD(DH)) dut (
    .clk(clk), .reset(reset), .flap(flap), .collide(collide),
    .pipe0_x(pipe0_x), .pipe1_x(pipe1_x), .pipes_reset(pipes_reset),
    .start0(start0), .start1(start1), .pipe_length0(pipe_length0),
    .pipe_length1(pipe_length1), .score(score),
`ifdef HIGH_SCORE_EN
    .high_score(high_score),
`endif
    .playing(playing), .game_over(game_over));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick_x();
    int r = $urandom_range(0, 7);
    return r == 0 ? 640 : r == 1 ? 320 : r == 2 ? 321 : r == 3 ? 100 :
           r == 4 ? 101 : r == 5 ? 100 : r == 6 ? 639 : int'($urandom_range(0, 2047));
  endfunction

  task automatic model_step(input int r, input int f, input int c, input int x0, input int x1);
    int inc;
    if (r != 0) begin
      m_state = 0; m_score = 0; m_hs = 0; m_cnt = 0; m_armed = 0;
      m_lfsr = 'h2A5; m_len0 = 'h2A5; m_len1 = 'h2A5; m_prev0 = 640; m_prev1 = 640;
      return;
    end
    if (x0 == 640) m_len0 = m_lfsr;
    if (x1 == 640) m_len1 = m_lfsr;
    m_lfsr = ((m_lfsr * 2) % 1024) + (((m_lfsr / 512) + (m_lfsr / 64)) % 2);
    if (m_state == 0) begin
      if (f != 0) begin m_state = 1; m_score = 0; end
    end else if (m_state == 1) begin
      if (c != 0) begin
        m_state = 2; m_cnt = 0;
        if (m_score > m_hs) m_hs = m_score;
      end else begin
        if (x0 <= 320) m_armed = 1;
        inc = (x0 == 100 && m_prev0 != 100 ? 1 : 0) + (x1 == 100 && m_prev1 != 100 ? 1 : 0);
        m_score = m_score + inc > 999 ? 999 : m_score + inc;
      end
    end else begin
      if (f != 0 && m_cnt >= DH) begin m_state = 0; m_armed = 0; m_cnt = 0; end
      else if (m_cnt < DH) m_cnt++;
    end
    m_prev0 = x0; m_prev1 = x1;
  endtask

  task automatic cycle(input int r, input int f, input int c, input int x0, input int x1);
    @(negedge clk);
    reset = r[0]; flap = f[0]; collide = c[0];
    pipe0_x = 11'(x0); pipe1_x = 11'(x1);
    @(posedge clk);
    model_step(r, f, c, x0, x1);
    #1;
    check("pipes_reset", int'(pipes_reset), m_state == 0 ? 1 : 0);
    check("start0", int'(start0), m_state == 1 ? 1 : 0);
    check("start1", int'(start1), m_state == 1 && m_armed != 0 ? 1 : 0);
    check("playing", int'(playing), m_state == 1 ? 1 : 0);
    check("game_over", int'(game_over), m_state == 2 ? 1 : 0);
    check("score", int'(score), m_score);
    check("pipe_length0", int'(pipe_length0), m_len0);
    check("pipe_length1", int'(pipe_length1), m_len1);
`ifdef HIGH_SCORE_EN
    check("high_score", int'(high_score), m_hs);
`endif
  endtask

  function automatic int hit(input int den);
    return den > 0 && $urandom_range(1, den) == 1 ? 1 : 0;
  endfunction

  task automatic run(input int n, input int pf, input int pc, input int pr);
    for (int i = 0; i < n; i++)
      cycle(hit(pr), hit(pf), hit(pc), pick_x(), pick_x());
  endtask

  initial begin
    cycle(1, 0, 0, 640, 640);
    cycle(1, 0, 0, 640, 640);
    check("reset_score", int'(score), 0);
    check("reset_len0", int'(pipe_length0), 'h2A5);
    cycle(0, 0, 0, 640, 640);
    check("first_lfsr", int'(pipe_length0), 'h2A5);
    cycle(0, 0, 0, 640, 640);
    check("second_lfsr", int'(pipe_length0), 'h14B);
    run(4000, 4, 40, 1500);
    run(8000, 4, 0, 0);
    check("saturated", int'(score), 999);
    run(4000, 4, 30, 2000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
